// File: rtl/rr_mux_sched.sv
// rr_mux_sched: round-robin scheduler driving a shared 8:1 bit-select mux,
// with bounded grant hold and a registered copy of the selected data bit.
module rr_mux_sched #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] i,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       y
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] hold_cnt;
    logic [2:0] start;
    logic [2:0] win;
    logic       found;
    logic       rel;

    assign rel = !req[sel] || hold_cnt == 4'(MAX_HOLD);

    // Descending scan so the lowest offset from start is the last to win
    always_comb begin
        start = (state == GRANT) ? sel + 3'd1 : ptr;
        found = 1'b0;
        win   = start;
        for (int k = 7; k >= 0; k--)
            if (req[start + 3'(k)]) begin
                found = 1'b1;
                win   = start + 3'(k);
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= 4'd0;
            sel      <= 3'd0;
            gnt      <= 8'd0;
            busy     <= 1'b0;
            y        <= 1'b0;
        end else begin
            y <= busy ? i[sel] : 1'b0;
            if (state == IDLE || rel) begin
                if (state == GRANT)
                    ptr <= sel + 3'd1;
                if (found) begin
                    sel      <= win;
                    gnt      <= 8'd1 << win;
                    busy     <= 1'b1;
                    hold_cnt <= 4'd1;
                    state    <= GRANT;
                end else begin
                    gnt   <= 8'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end else begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_sched.sv
// tb_rr_mux_sched: scoreboard bench for rr_mux_sched (MAX_HOLD=4 and MAX_HOLD=1).
module tb_rr_mux_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] i = 8'd0;
    logic [2:0] sel, sel1;
    logic [7:0] gnt, gnt1;
    logic       busy, busy1, y, y1;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] s;
        logic [3:0] h;
    } exp_t;

    exp_t q[$];
    logic yq[$];

    rr_mux_sched #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .i(i),
        .sel(sel), .gnt(gnt), .busy(busy), .y(y)
    );

    rr_mux_sched #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .i(i),
        .sel(sel1), .gnt(gnt1), .busy(busy1), .y(y1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        req   = 8'd0;
        i     = 8'd0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1 req = 8'hFF;
        rst_n = 1'b0;
        #2;
        compared++;
        if ({sel, gnt, busy, y} !== 13'd0) begin
            mismatched++;
            $display("FAIL reset_async: sel=%0d gnt=%h busy=%b y=%b, want all 0", sel, gnt, busy, y);
        end
        @(posedge clk);
        #1 req = 8'd0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            compared++;
            if ({sel, gnt, busy, y} !== 13'd0) begin
                mismatched++;
                $display("FAIL reset_idle[%0d]: sel=%0d gnt=%h busy=%b y=%b, want all 0", c, sel, gnt, busy, y);
            end
        end
    endtask

    task automatic test_full_contention();
        exp_t e;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++)
            for (int h = 1; h <= 4; h++)
                q.push_back('{g: 8'd1 << (k % 8), s: 3'(k % 8), h: 4'(h)});
        while (q.size() > 0) begin
            @(posedge clk);
            #1 e = q.pop_front();
            compared++;
            if (gnt !== e.g || sel !== e.s || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL full_contention: gnt=%h sel=%0d busy=%b, want gnt=%h sel=%0d busy=1", gnt, sel, busy, e.g, e.s);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        req = 8'h04;
        for (int c = 0; c < 12; c++)
            q.push_back('{g: 8'h04, s: 3'd2, h: 4'(c % 4 + 1)});
        while (q.size() > 0) begin
            @(posedge clk);
            #1 e = q.pop_front();
            compared++;
            if (gnt !== e.g || sel !== e.s || dut.hold_cnt !== e.h) begin
                mismatched++;
                $display("FAIL single_req: gnt=%h sel=%0d hold=%0d, want gnt=%h sel=%0d hold=%0d",
                         gnt, sel, dut.hold_cnt, e.g, e.s, e.h);
            end
        end
    endtask

    task automatic test_early_drop();
        exp_t e;
        do_reset();
        req = 8'h09;
        q.push_back('{g: 8'h01, s: 3'd0, h: 4'd1});
        q.push_back('{g: 8'h01, s: 3'd0, h: 4'd2});
        q.push_back('{g: 8'h08, s: 3'd3, h: 4'd1});
        q.push_back('{g: 8'h08, s: 3'd3, h: 4'd2});
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 e = q.pop_front();
            compared++;
            if (gnt !== e.g || sel !== e.s) begin
                mismatched++;
                $display("FAIL early_drop[%0d]: gnt=%h sel=%0d, want gnt=%h sel=%0d", c, gnt, sel, e.g, e.s);
            end
            if (c == 1)
                req = 8'h08;
        end
    endtask

    task automatic test_data_path();
        logic [7:0] pat;
        logic ey;
        do_reset();
        pat = 8'b10110110;
        i   = pat;
        req = 8'hFF;
        for (int k = 0; k < 8; k++)
            yq.push_back(pat[k]);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (c <= 8) begin
                compared++;
                if (sel1 !== 3'(c - 1) || gnt1 !== 8'd1 << (c - 1)) begin
                    mismatched++;
                    $display("FAIL data_sel[%0d]: sel=%0d gnt=%h, want sel=%0d gnt=%h", c, sel1, gnt1, c - 1, 8'd1 << (c - 1));
                end
            end
            if (c == 1) begin
                compared++;
                if (y1 !== 1'b0) begin
                    mismatched++;
                    $display("FAIL data_y_first: y=%b, want 0", y1);
                end
            end else begin
                ey = yq.pop_front();
                compared++;
                if (y1 !== ey) begin
                    mismatched++;
                    $display("FAIL data_y[%0d]: y=%b, want %b", c, y1, ey);
                end
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        i   = 8'hFF;
        req = 8'h20;
        @(posedge clk);
        @(posedge clk);
        #1;
        compared++;
        if (sel !== 3'd5 || gnt !== 8'h20 || busy !== 1'b1 || y !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_pre: sel=%0d gnt=%h busy=%b y=%b, want sel=5 gnt=20 busy=1 y=1", sel, gnt, busy, y);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({sel, gnt, busy, y} !== 13'd0) begin
            mismatched++;
            $display("FAIL mid_reset: sel=%0d gnt=%h busy=%b y=%b, want all 0", sel, gnt, busy, y);
        end
        req = 8'h21;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            mismatched++;
            $display("FAIL mid_restart: gnt=%h sel=%0d, want gnt=01 sel=0", gnt, sel);
        end
    endtask

    initial begin
        test_reset();
        test_full_contention();
        test_single();
        test_early_drop();
        test_data_path();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
